// File: rtl/keyinput_loader.sv
// keyinput_loader: serial LSB-first key intake into a shadow register,
// even-parity check, then glitch-free commit to the locked key bus.
module keyinput_loader #(
    parameter int KEY_W = 32,
    parameter int CNT_W = $clog2(KEY_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             exp_par,
    input  logic             clear,
    input  logic             ser_valid,
    input  logic             ser_data,
    output logic             ser_ready,
    output logic             busy,
    output logic             key_valid,
    output logic             key_error,
    output logic [KEY_W-1:0] keyinput
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(KEY_W - 1);

    state_t             state, state_d;
    logic [KEY_W-1:0]   shadow, shadow_d;
    logic [CNT_W-1:0]   count, count_d;
    logic               par_q, par_d;
    logic [KEY_W-1:0]   key_d;
    logic               kv_d, ke_d;
    logic               accept;

    assign ser_ready = (state == SHIFT);
    assign busy      = (state == SHIFT) || (state == CHECK);
    assign accept    = ser_valid && ser_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and datapath update; clear overrides every state
    always_comb begin
        state_d  = state;
        shadow_d = shadow;
        count_d  = count;
        par_d    = par_q;
        key_d    = keyinput;
        kv_d     = key_valid;
        ke_d     = key_error;
        if (clear) begin
            state_d  = IDLE;
            shadow_d = '0;
            count_d  = '0;
            key_d    = '0;
            kv_d     = 1'b0;
            ke_d     = 1'b0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (start) begin
                        par_d    = exp_par;
                        shadow_d = '0;
                        count_d  = '0;
                        kv_d     = 1'b0;
                        ke_d     = 1'b0;
                        state_d  = SHIFT;
                    end
                end
                (state == SHIFT): begin
                    if (accept) begin
                        shadow_d = shadow | (KEY_W'(ser_data) << count);
                        count_d  = count + CNT_W'(1);
                        if (count == LAST) begin
                            state_d = CHECK;
                        end
                    end
                end
                (state == CHECK): begin
                    if ((^shadow) == par_q) begin
                        key_d = shadow;
                        kv_d  = 1'b1;
                    end else begin
                        key_d = '0;
                        ke_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Datapath and committed-key registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            count     <= '0;
            par_q     <= 1'b0;
            keyinput  <= '0;
            key_valid <= 1'b0;
            key_error <= 1'b0;
        end else begin
            shadow    <= shadow_d;
            count     <= count_d;
            par_q     <= par_d;
            keyinput  <= key_d;
            key_valid <= kv_d;
            key_error <= ke_d;
        end
    end

endmodule

// File: tb/tb_keyinput_loader.sv
// tb_keyinput_loader: directed loads; expected load results are queued
// by the stimulus and checked by a monitor when busy falls.
module tb_keyinput_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        exp_par;
    logic        clear;
    logic        ser_valid;
    logic        ser_data;
    logic        ser_ready;
    logic        busy;
    logic        key_valid;
    logic        key_error;
    logic [31:0] keyinput;

    typedef struct {
        logic [31:0] key;
        logic        kv;
        logic        ke;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic busy_q = 1'b0;

    keyinput_loader #(.KEY_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .exp_par   (exp_par),
        .clear     (clear),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready),
        .busy      (busy),
        .key_valid (key_valid),
        .key_error (key_error),
        .keyinput  (keyinput)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] k, input logic kv,
                        input logic ke);
        exp_t e;
        e.key = k;
        e.kv  = kv;
        e.ke  = ke;
        sbq.push_back(e);
    endtask

    task automatic do_start(input logic ep);
        start   = 1'b1;
        exp_par = ep;
        tick();
        start   = 1'b0;
    endtask

    task automatic stream(input logic [31:0] k, input int gap,
                          input int lo, input int hi,
                          input bit chk_prev, input logic [31:0] prev,
                          output int cyc);
        int   i;
        int   guard;
        bit   done;
        logic acc;
        i     = lo;
        cyc   = 0;
        guard = 0;
        done  = 1'b0;
        while (i <= hi && guard < 500) begin
            ser_data  = k[i];
            ser_valid = 1'b1;
            acc       = ser_ready;
            if (chk_prev && !done && i == (lo + hi) / 2) begin
                chk("key_stable_in_shift", keyinput, prev);
                done = 1'b1;
            end
            tick();
            cyc++;
            if (acc) i++;
            ser_valid = 1'b0;
            if (i <= hi && gap > 0) begin
                repeat (gap) tick();
                cyc += gap;
            end
            guard++;
        end
        ser_valid = 1'b0;
        chk("stream_bits_accepted", 32'(i), 32'(hi + 1));
    endtask

    task automatic wait_done();
        chk("check_ser_ready", {31'b0, ser_ready}, 32'd0);
        chk("check_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("done_busy", {31'b0, busy}, 32'd0);
        tick();
    endtask

    // Result monitor: a load or abort ends when busy falls
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_q = 1'b0;
        end else begin
            if (busy_q && !busy) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got key %h expected none",
                             keyinput);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("result_key", keyinput, e.key);
                    chk("result_key_valid", {31'b0, key_valid}, {31'b0, e.kv});
                    chk("result_key_error", {31'b0, key_error}, {31'b0, e.ke});
                end
            end
            busy_q = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        start     = 1'b0;
        exp_par   = 1'b0;
        clear     = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_keyinput", keyinput, 32'h0);
        chk("rst_key_valid", {31'b0, key_valid}, 32'd0);
        chk("rst_key_error", {31'b0, key_error}, 32'd0);
        chk("rst_ser_ready", {31'b0, ser_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);

        // good load
        push(32'hA5A50F0F, 1'b1, 1'b0);
        do_start(1'b0);
        chk("start_ready_latency", {31'b0, ser_ready}, 32'd1);
        stream(32'hA5A50F0F, 0, 0, 31, 1'b1, 32'h0, cyc);
        chk("good_ready_cycles", 32'(cyc), 32'd32);
        wait_done();

        // parity failure, previous key held during shift
        push(32'h0, 1'b0, 1'b1);
        do_start(1'b1);
        chk("start_clears_valid", {31'b0, key_valid}, 32'd0);
        stream(32'hA5A50F0F, 0, 0, 31, 1'b1, 32'hA5A50F0F, cyc);
        wait_done();

        // good load after failure
        push(32'hA5A50F0F, 1'b1, 1'b0);
        do_start(1'b0);
        chk("start_clears_error", {31'b0, key_error}, 32'd0);
        stream(32'hA5A50F0F, 0, 0, 31, 1'b0, 32'h0, cyc);
        wait_done();

        // throttled stream 1,0,0,1...
        push(32'h00000001, 1'b1, 1'b0);
        do_start(1'b1);
        stream(32'h00000001, 2, 0, 31, 1'b1, 32'hA5A50F0F, cyc);
        chk("throttle_cycles", 32'(cyc), 32'd94);
        wait_done();

        // abort after 10 bits
        push(32'h0, 1'b0, 1'b0);
        do_start(1'b0);
        stream(32'h3C3C3C3C, 0, 0, 9, 1'b0, 32'h0, cyc);
        clear     = 1'b1;
        ser_valid = 1'b1;
        ser_data  = 1'b1;
        tick();
        clear     = 1'b0;
        ser_valid = 1'b0;
        chk("abort_keyinput", keyinput, 32'h0);
        chk("abort_key_valid", {31'b0, key_valid}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        tick();
        push(32'h3C3C3C3C, 1'b1, 1'b0);
        do_start(1'b0);
        stream(32'h3C3C3C3C, 0, 0, 31, 1'b0, 32'h0, cyc);
        wait_done();

        // misuse: valid in IDLE, start mid-shift, valid in CHECK
        ser_valid = 1'b1;
        ser_data  = 1'b1;
        repeat (3) tick();
        ser_valid = 1'b0;
        chk("idle_valid_busy", {31'b0, busy}, 32'd0);
        chk("idle_valid_ready", {31'b0, ser_ready}, 32'd0);
        push(32'h12345678, 1'b1, 1'b0);
        do_start(1'b1);
        stream(32'h12345678, 0, 0, 15, 1'b0, 32'h0, cyc);
        do_start(1'b0);
        stream(32'h12345678, 0, 16, 31, 1'b0, 32'h0, cyc);
        ser_valid = 1'b1;
        ser_data  = 1'b1;
        wait_done();
        ser_valid = 1'b0;

        // start and clear together
        start   = 1'b1;
        clear   = 1'b1;
        exp_par = 1'b0;
        tick();
        start = 1'b0;
        clear = 1'b0;
        chk("sc_busy", {31'b0, busy}, 32'd0);
        chk("sc_ready", {31'b0, ser_ready}, 32'd0);
        chk("sc_keyinput", keyinput, 32'h0);
        chk("sc_key_valid", {31'b0, key_valid}, 32'd0);
        tick();
        chk("sc_still_idle", {31'b0, busy}, 32'd0);

        // async reset mid-shift
        push(32'hA5A50F0F, 1'b1, 1'b0);
        do_start(1'b0);
        stream(32'hA5A50F0F, 0, 0, 31, 1'b0, 32'h0, cyc);
        wait_done();
        do_start(1'b1);
        stream(32'hFFFFFFFF, 0, 0, 4, 1'b0, 32'h0, cyc);
        rst_n = 1'b0;
        #1;
        chk("arst_keyinput", keyinput, 32'h0);
        chk("arst_key_valid", {31'b0, key_valid}, 32'd0);
        chk("arst_key_error", {31'b0, key_error}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_ready", {31'b0, ser_ready}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keyinput_loader.md
Name: keyinput_loader

Overview:
- Upstream key-delivery stage for the locked combinational netlists (keyinput0..keyinput31 style key buses).
- Receives a key serially, LSB first, over a valid/ready bit stream into a shadow register, then parity-checks the assembled key.
- On a successful check, commits the shadow register to a parallel key bus that drives the locked circuit's key inputs.
- The committed bus stays stable between loads, so the SAT-simulation oracle sees a glitch-free key.

Parameters:
- KEY_W, 32, key width in bits; must match the locked netlist's keyinput count (>=2).
- CNT_W, $clog2(KEY_W+1), bit-counter width; derived, do not override.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load. Sampled only in IDLE.
- exp_par  in  1  expected even-parity bit of the key (XOR of all key bits); latched with start.
- clear  in  1  synchronous abort/zeroise; highest priority after reset.
- ser_valid  in  1  serial bit valid.
- ser_data  in  1  serial key bit, LSB (keyinput0) first.
- ser_ready  out  1  loader accepts a bit this cycle.
- busy  out  1  high in SHIFT and CHECK.
- key_valid  out  1  committed key is good and applied.
- key_error  out  1  sticky parity failure on the last load.
- keyinput  out  KEY_W  committed key; bit i drives keyinput<i>.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; keyinput=0; shadow=0; count=0; ser_ready=0; busy=0; key_valid=0; key_error=0.
- All outputs are registered; ser_ready and busy decode from the state register.
- States:
  - IDLE: ser_ready=0. On start, latch exp_par, clear count and shadow, set key_valid=0 and key_error=0, go to SHIFT next cycle. keyinput keeps its previous value.
  - SHIFT: ser_ready=1, busy=1. A bit is accepted on a cycle with ser_valid && ser_ready: shadow[count] <= ser_data, count++. When the KEY_W-th bit is accepted (count == KEY_W-1 at accept), go to CHECK. ser_valid gaps hold state indefinitely; there is no timeout.
  - CHECK (exactly 1 cycle): ser_ready=0, busy=1. If ^shadow == exp_par_latched: keyinput <= shadow, key_valid <= 1. Otherwise: keyinput <= 0, key_error <= 1, key_valid stays 0. Then go to IDLE.
- Latency: start pulse to first ser_ready=1 is 1 cycle. Last accepted bit to key_valid/key_error visible is 2 clock edges (edge into CHECK, edge out of CHECK). Minimum full load is KEY_W+2 cycles after start.
- start while busy: ignored, with no effect on the load in progress.
- start and clear in the same cycle: clear wins, and start is dropped.
- clear (any state): next cycle state=IDLE, keyinput=0, shadow=0, count=0, key_valid=0, key_error=0. A bit presented with ser_valid in the clear cycle is not accepted.
- ser_valid while ser_ready=0 (IDLE or CHECK): bit is discarded, with no state change.
- Counter never wraps: CHECK is entered exactly at KEY_W accepted bits, and count is cleared on start or clear.
- keyinput changes only on the CHECK edge, on clear, or on reset. It never changes during SHIFT, so the previous key stays applied throughout a reload.
- key_error stays set until the next start or clear.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, release -> keyinput=0x00000000, key_valid=0, key_error=0, ser_ready=0. rst_n asserted mid-SHIFT -> all outputs 0 immediately, without waiting for a clock edge.
- Good load: start with exp_par=0, stream 0xA5A50F0F LSB-first with ser_valid held high -> ser_ready high for 32 cycles, then CHECK; 2 edges after bit 31, keyinput=0xA5A50F0F, key_valid=1, busy=0.
- Parity fail: same stream with exp_par=1 -> keyinput=0x00000000, key_error=1, key_valid=0. A following good load clears key_error at start and ends with key_valid=1.
- Throttled stream: ser_valid toggling 1,0,0,1... over key 0x00000001 with exp_par=1 -> load completes after exactly 32 accepted bits, keyinput=0x00000001. The prior key stays on keyinput throughout SHIFT.
- Abort: clear asserted after 10 accepted bits -> next cycle IDLE, keyinput=0, key_valid=0. A later start plus full 32-bit stream loads correctly, proving count restarted at 0.
- Protocol misuse: start pulsed mid-SHIFT, and ser_valid=1 in IDLE and in CHECK -> no extra bits captured, final key correct; start+clear in the same cycle -> remains IDLE.
